dsp_fetch: RTL and testbench

- Instruction fetch unit for the DSP core. It sits at the consuming end of the branch-resolution interface (jump_flag/jump_addr).
- Owns the program counter and issues reads to a 1-cycle-latency synchronous instruction memory.
- Buffers fetched words in a small prefetch queue and hands them to decode over a valid/ready handshake.
- A taken jump flushes the queue, squashes any in-flight read and redirects the PC.

---
 rtl/dsp_fetch_pkg.sv | 25 ++
 rtl/dsp_fetch_queue.sv | 43 ++++
 rtl/dsp_fetch.sv | 111 +++++++++++
 tb/tb_dsp_fetch.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dsp_fetch_pkg.sv
// dsp_fetch_pkg: shared widths and FSM encodings for the instruction fetch unit.
// The legacy width/encoding macros are defined here so every file that
// imports the package sees one consistent definition.
`ifndef MEM_ADDR_LEN
`define MEM_ADDR_LEN 16
`endif
`ifndef REG_WORD_LEN
`define REG_WORD_LEN 16
`endif
`ifndef FETCH_S_RESET
`define FETCH_S_RESET    2'd0
`define FETCH_S_RUN      2'd1
`define FETCH_S_REDIRECT 2'd2
`endif

package dsp_fetch_pkg;
  localparam int ADDR_W_DEF  = `MEM_ADDR_LEN;
  localparam int INSTR_W_DEF = `REG_WORD_LEN;

  typedef enum logic [1:0] {
    S_RESET    = `FETCH_S_RESET,
    S_RUN      = `FETCH_S_RUN,
    S_REDIRECT = `FETCH_S_REDIRECT
  } fetch_state_e;
endpackage

// File: rtl/dsp_fetch_queue.sv
// dsp_fetch_queue: DEPTH-entry FIFO of {addr, instr} words.
// Synchronous flush wins over a same-cycle push; the caller guarantees
// no push into a full queue and no pop from an empty one.
module dsp_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_cnt
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [PW:0]   r_cnt;

  // Storage array: written on push, contents need no reset.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(i_push) - (PW+1)'(i_pop);
    end
  end

  assign o_head = r_mem[r_rd];
  assign o_cnt  = r_cnt;
endmodule

// File: rtl/dsp_fetch.sv
// dsp_fetch: instruction fetch unit. Owns the PC, issues reads to a
// 1-cycle synchronous instruction memory, buffers words in a prefetch
// queue and hands them to decode on a valid/ready handshake. A taken
// jump flushes the queue, drops the returning word and redirects the PC.
// Optional: define DSP_FETCH_PERF_EN to add fetch_count/flush_count.
module dsp_fetch
  import dsp_fetch_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(16'h0000),
  parameter int                DEPTH     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jump_flag,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_addr
`ifdef DSP_FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [15:0]        flush_count
`endif
);
  localparam int QW = ADDR_W + INSTR_W;
  localparam int CW = $clog2(DEPTH) + 2;

  fetch_state_e          r_state, w_state_nxt;
  logic [ADDR_W-1:0]     r_pc, r_fly_addr;
  logic                  r_inflight;
  logic                  w_jump, w_pop, w_push, w_issue;
  logic [QW-1:0]         w_head;
  logic [$clog2(DEPTH):0] w_cnt;
  logic [CW-1:0]         w_credit;

  // Only a clean 1 is a taken jump; ignored while still leaving reset.
  assign w_jump   = (jump_flag === 1'b1) && (r_state != S_RESET);
  assign w_pop    = instr_valid && instr_ready;
  // Slots already claimed after this cycle: queued + returning - leaving.
  assign w_credit = CW'(w_cnt) + CW'(r_inflight) - CW'(w_pop);
  assign w_issue  = (r_state == S_RUN) && !w_jump && (w_credit < CW'(DEPTH));
  assign w_push   = r_inflight && !w_jump;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_nxt;
  end

  // Next state: one bubble after every accepted jump.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET:    w_state_nxt = S_RUN;
      S_RUN:      if (w_jump) w_state_nxt = S_REDIRECT;
      S_REDIRECT: w_state_nxt = w_jump ? S_REDIRECT : S_RUN;
      default:    w_state_nxt = S_RESET;
    endcase
  end

  // PC and in-flight tracking; the issuing address travels with the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_inflight <= 1'b0;
      r_fly_addr <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_fly_addr <= r_pc;
      if (w_jump)       r_pc <= jump_addr;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
    end
  end

  dsp_fetch_queue #(.DEPTH(DEPTH), .W(QW)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_jump),
    .i_data  ({r_fly_addr, imem_rdata}),
    .o_head  (w_head),
    .o_cnt   (w_cnt)
  );

  assign imem_rd_en  = w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = (w_cnt != '0);
  // Head is forced to zero when empty so stale entries never show.
  assign instr_data  = instr_valid ? w_head[INSTR_W-1:0]  : '0;
  assign instr_addr  = instr_valid ? w_head[QW-1:INSTR_W] : '0;

`ifdef DSP_FETCH_PERF_EN
  // Saturating handshake and flush counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (w_pop  && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (w_jump && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dsp_fetch.sv
// tb_dsp_fetch: directed scenarios plus randomized ready/jump/reset traffic.
// The reference is a program-order model: the next word decode should see
// and the next address memory should be asked for, both redirected by jumps.
`timescale 1ns/1ps
module tb_dsp_fetch;
  logic        clk = 1'b0;
  logic        rst, jump_flag, instr_ready;
  logic [15:0] jump_addr;
  logic        imem_rd_en, instr_valid;
  logic [15:0] imem_addr, imem_rdata, instr_data, instr_addr;
`ifdef DSP_FETCH_PERF_EN
  logic [15:0] fetch_count, flush_count;
`endif

  always #5 clk = ~clk;

  dsp_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_addr  (instr_addr)
`ifdef DSP_FETCH_PERF_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  // Instruction memory: mem[a] = a ^ 16'hA5A5, garbage when not read.
  always @(posedge clk)
    imem_rdata <= imem_rd_en ? (imem_addr ^ 16'hA5A5) : 16'hDEAD;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [15:0] exp_del, exp_fetch;
  int          since_rst, since_jump, n_pop, n_flush;
  logic        s_valid, s_rd_en;

  // One clock: drive at negedge, check just before the posedge, advance.
  task automatic cyc(input logic r, input logic jf, input logic [15:0] ja, input logic rdy);
    logic acc;
    @(negedge clk);
    rst = r; jump_flag = jf; jump_addr = ja; instr_ready = rdy;
    #2;
    s_valid = instr_valid;
    s_rd_en = imem_rd_en;
    if (r) begin
      exp_del = 16'h0000; exp_fetch = 16'h0000;
      since_rst = 0; since_jump = 100; n_pop = 0; n_flush = 0;
    end else begin
      acc = jf && (since_rst != 0);
`ifdef DSP_FETCH_PERF_EN
      chk("fetch_count", fetch_count, n_pop);
      chk("flush_count", flush_count, n_flush);
`endif
      if (since_rst == 0) begin
        chk("rst_rd_en", imem_rd_en, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_data", instr_data, 0);
        chk("rst_addr", instr_addr, 0);
        chk("rst_pc", imem_addr, 16'h0000);
      end
      if (since_rst == 1 && !jf) chk("first_rd", imem_rd_en, 1);
      if (since_jump == 1) begin
        chk("bubble_rd_en", imem_rd_en, 0);
        chk("flush_valid", instr_valid, 0);
      end
      if (since_jump == 2 && !jf) chk("redirect_rd", imem_rd_en, 1);
      if (instr_valid && rdy) begin
        chk("del_addr", instr_addr, exp_del);
        chk("del_data", instr_data, exp_del ^ 16'hA5A5);
        exp_del++;
        n_pop++;
      end
      if (imem_rd_en) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        exp_fetch++;
      end
      if (acc) begin
        chk("jump_no_rd", imem_rd_en, 0);
        exp_del = ja; exp_fetch = ja;
        n_flush++;
        since_jump = 1;
      end else if (since_jump < 100) since_jump++;
      if (since_rst < 100) since_rst++;
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; jump_flag = 1'b0; jump_addr = '0; instr_ready = 1'b1;
    exp_del = '0; exp_fetch = '0; since_rst = 0; since_jump = 100;
    n_pop = 0; n_flush = 0;

    // Streaming from reset: no gaps once the first word arrives.
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 0, 1);
      if (i >= 3) chk("nogap_valid", s_valid, 1);
    end

    // Decode stall: queue fills, reads stop, then drains in order.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (i >= 3) begin
        chk("stall_rd_en", s_rd_en, 0);
        chk("stall_valid", s_valid, 1);
      end
    end
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1);

    // Jump while the read of address 5 is in flight.
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1);
    cyc(0, 1, 16'h0040, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Address wrap from 0xFFFF to 0x0000.
    cyc(0, 1, 16'hFFFF, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Back-to-back jumps: only the second target is fetched.
    cyc(0, 1, 16'h0010, 1);
    cyc(0, 1, 16'h0020, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Reset mid-stream with a read in flight; a jump while leaving reset is ignored.
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    cyc(0, 1, 16'h1234, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // Randomized ready, jumps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic        r, jf, rdy;
      logic [15:0] ja;
      r   = ($urandom_range(0, 499) == 0);
      jf  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ja  = 16'($urandom);
      cyc(r, jf, ja, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
